// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for MUL/MLA: one partial product per cycle,
// fixed WIDTH-cycle latency, then a single-cycle register write-back request.
module mul_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mla,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] acc,
  input  logic [3:0]       wa_in,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             we_out,
  output logic [3:0]       wa_out,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  mcand_reg, mcand_next;
  logic [WIDTH-1:0]  mplier_reg, mplier_next;
  logic [WIDTH-1:0]  sum_reg, sum_next;
  logic [CNTW-1:0]   count_reg, count_next;
  logic [3:0]        wa_reg, wa_next;
  logic              flag_n_reg, flag_n_next;
  logic              flag_z_reg, flag_z_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      sum_reg    <= '0;
      count_reg  <= '0;
      wa_reg     <= '0;
      flag_n_reg <= 1'b0;
      flag_z_reg <= 1'b0;
    end else begin
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      sum_reg    <= sum_next;
      count_reg  <= count_next;
      wa_reg     <= wa_next;
      flag_n_reg <= flag_n_next;
      flag_z_reg <= flag_z_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    sum_next    = sum_reg;
    count_next  = count_reg;
    wa_next     = wa_reg;
    flag_n_next = flag_n_reg;
    flag_z_next = flag_z_reg;

    // A flush freezes the datapath where it stands so result/wa_out keep their values.
    if (flush) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            mcand_next  = op_a;
            mplier_next = op_b;
            sum_next    = mla ? acc : '0;
            wa_next     = wa_in;
            count_next  = '0;
            state_next  = RUN;
          end
        end
        RUN: begin
          if (mplier_reg[0]) begin
            sum_next = sum_reg + mcand_reg;
          end
          mcand_next  = mcand_reg << 1;
          mplier_next = mplier_reg >> 1;
          count_next  = count_reg + 1'b1;
          if (count_reg == CNTW'(WIDTH - 1)) begin
            // Flags are latched from the final sum so they only change on completion.
            flag_n_next = sum_next[WIDTH-1];
            flag_z_next = (sum_next == '0);
            count_next  = '0;
            state_next  = DONE;
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == DONE);
  assign we_out = done;
  assign wa_out = wa_reg;
  assign result = sum_reg;
  assign flag_n = flag_n_reg;
  assign flag_z = flag_z_reg;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed and random MUL/MLA operations
// against an arithmetic reference, plus restart, flush and async-reset scenarios.
module tb_mul_unit;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic             mla;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [3:0]       wa_in;
  logic             flush;
  logic             busy;
  logic             done;
  logic             we_out;
  logic [3:0]       wa_out;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_z;

  int vectors;
  int miscompares;

  mul_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mla(mla),
    .op_a(op_a), .op_b(op_b), .acc(acc), .wa_in(wa_in), .flush(flush),
    .busy(busy), .done(done), .we_out(we_out), .wa_out(wa_out),
    .result(result), .flag_n(flag_n), .flag_z(flag_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: low WIDTH bits of a*b (+acc), computed in wide arithmetic.
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] c, input logic m);
    logic [2*WIDTH-1:0] full;
    full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b} + (m ? {{WIDTH{1'b0}}, c} : '0);
    return full[WIDTH-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until done is seen or the bound expires; cyc tracks the cycle number.
  task automatic wait_done(input int from_cyc, output int cyc);
    cyc = from_cyc;
    while (done !== 1'b1 && cyc < from_cyc + 3 * WIDTH) begin
      tick();
      cyc++;
    end
  endtask

  task automatic set_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] c, input logic m, input logic [3:0] w);
    op_a = a; op_b = b; acc = c; mla = m; wa_in = w;
  endtask

  task automatic scramble_inputs();
    op_a = $urandom; op_b = $urandom; acc = $urandom; mla = 1'($urandom); wa_in = 4'($urandom);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; flush = 1'b0;
    set_op('0, '0, '0, 1'b0, 4'd0);
    tick(); tick();
    vectors++;
    if ({busy, done, we_out, wa_out, result, flag_n, flag_z} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b we=%b wa=%h res=%h n=%b z=%b want all 0",
               busy, done, we_out, wa_out, result, flag_n, flag_z);
    end
    reset_n = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  // Directed table followed by random operations, issued back to back.
  task automatic test_mul_mla();
    logic [WIDTH-1:0] ta [7];
    logic [WIDTH-1:0] tbv[7];
    logic [WIDTH-1:0] tc [7];
    logic             tm [7];
    logic [WIDTH-1:0] a, b, c, exp;
    logic             m;
    logic [3:0]       w;
    int               cyc;
    ta[0] = 32'd3;          tbv[0] = 32'd5; tc[0] = 32'd0;          tm[0] = 1'b0;
    ta[1] = 32'hFFFFFFFF;   tbv[1] = 32'd2; tc[1] = 32'd5;          tm[1] = 1'b1;
    ta[2] = 32'hFFFFFFFF;   tbv[2] = 32'd2; tc[2] = 32'd5;          tm[2] = 1'b0;
    ta[3] = 32'h12345678;   tbv[3] = 32'd0; tc[3] = 32'd9;          tm[3] = 1'b0;
    ta[4] = 32'h80000000;   tbv[4] = 32'd1; tc[4] = 32'd0;          tm[4] = 1'b0;
    ta[5] = 32'd1;          tbv[5] = 32'd1; tc[5] = 32'hFFFFFFFF;   tm[5] = 1'b1;
    ta[6] = 32'hFFFFFFFF;   tbv[6] = 32'hFFFFFFFF; tc[6] = 32'd0;   tm[6] = 1'b1;
    for (int i = 0; i < 7 + 24; i++) begin
      if (i < 7) begin
        a = ta[i]; b = tbv[i]; c = tc[i]; m = tm[i]; w = (i == 0) ? 4'd2 : 4'(i + 5);
      end else begin
        a = $urandom; b = $urandom; c = $urandom; m = 1'($urandom); w = 4'($urandom);
        if (i % 5 == 0) b = 32'($urandom_range(0, 15));
      end
      exp = model(a, b, c, m);
      set_op(a, b, c, m, w);
      start = 1'b1;
      tick();
      start = 1'b0;
      scramble_inputs();
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL op%0d_first_cycle: got busy=%b done=%b want busy=1 done=0", i, busy, done);
      end
      wait_done(1, cyc);
      vectors++;
      if (cyc !== LAT) begin
        miscompares++;
        $display("FAIL op%0d_latency: got done in cycle %0d want %0d", i, cyc, LAT);
      end
      vectors++;
      if (result !== exp || wa_out !== w || we_out !== 1'b1) begin
        miscompares++;
        $display("FAIL op%0d_writeback: got res=%h wa=%h we=%b want res=%h wa=%h we=1",
                 i, result, wa_out, we_out, exp, w);
      end
      vectors++;
      if (flag_n !== exp[WIDTH-1] || flag_z !== (exp == '0)) begin
        miscompares++;
        $display("FAIL op%0d_flags: got n=%b z=%b want n=%b z=%b",
                 i, flag_n, flag_z, exp[WIDTH-1], exp == '0);
      end
      tick();
      vectors++;
      if (done !== 1'b0 || we_out !== 1'b0 || busy !== 1'b0 || result !== exp) begin
        miscompares++;
        $display("FAIL op%0d_after_done: got done=%b we=%b busy=%b res=%h want 0 0 0 %h",
                 i, done, we_out, busy, result, exp);
      end
    end
  endtask

  task automatic test_restart_ignored();
    int cyc;
    logic seen_done;
    seen_done = 1'b0;
    set_op(32'd7, 32'd9, 32'd100, 1'b0, 4'd11);
    start = 1'b1;
    tick();
    cyc = 1;
    while (cyc < LAT) begin
      if (cyc == 5) begin
        set_op(32'd100, 32'd100, 32'd1, 1'b1, 4'd3);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) seen_done = 1'b1;
      tick();
      cyc++;
    end
    vectors++;
    if (seen_done !== 1'b0 || done !== 1'b1 || result !== 32'd63 || wa_out !== 4'd11) begin
      miscompares++;
      $display("FAIL restart_result: got early=%b done=%b res=%0d wa=%0d want early=0 done=1 res=63 wa=11",
               seen_done, done, result, wa_out);
    end
    set_op(32'd2, 32'd2, 32'd0, 1'b0, 4'd1);
    start = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_in_done_ignored: got busy=%b done=%b want 0 0", busy, done);
    end
    set_op(32'd11, 32'd13, 32'd0, 1'b0, 4'd6);
    tick();
    start = 1'b0;
    wait_done(1, cyc);
    vectors++;
    if (cyc !== LAT || result !== 32'd143 || wa_out !== 4'd6) begin
      miscompares++;
      $display("FAIL restart_next_op: got cyc=%0d res=%0d wa=%0d want cyc=%0d res=143 wa=6",
               cyc, result, wa_out, LAT);
    end
    tick();
  endtask

  task automatic test_flush();
    int cyc;
    logic seen_done;
    seen_done = 1'b0;
    set_op(32'd5, 32'd5, 32'd0, 1'b0, 4'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      tick();
      cyc++;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_run: got busy=%b done=%b want 0 0", busy, done);
    end
    for (int k = 0; k < LAT + 4; k++) begin
      if (done === 1'b1) seen_done = 1'b1;
      tick();
    end
    vectors++;
    if (seen_done !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_no_done: got done pulse=%b want 0", seen_done);
    end
    set_op(32'd3, 32'd3, 32'd0, 1'b0, 4'd4);
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_beats_start: got busy=%b want 0", busy);
    end
    tick();
  endtask

  task automatic test_async_reset();
    int cyc;
    set_op(32'hDEADBEEF, 32'hFFFFFFFF, 32'd0, 1'b0, 4'hA);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 15) begin
      tick();
      cyc++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, we_out, wa_out, result, flag_n, flag_z} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got busy=%b done=%b we=%b wa=%h res=%h n=%b z=%b want all 0",
               busy, done, we_out, wa_out, result, flag_n, flag_z);
    end
    tick();
    reset_n = 1'b1;
    set_op(32'd6, 32'd7, 32'd0, 1'b0, 4'd9);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1, cyc);
    vectors++;
    if (cyc !== LAT || result !== 32'd42 || wa_out !== 4'd9 || flag_z !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_op: got cyc=%0d res=%0d wa=%0d z=%b want cyc=%0d res=42 wa=9 z=0",
               cyc, result, wa_out, flag_z, LAT);
    end
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_mul_mla();
    test_restart_ignored();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
